// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: strobes one-hot-low columns, synchronizes the rows,
// classifies each full scan and debounces single-key presses and releases.
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_pressed_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic             tc, scan_done;
    logic [1:0]       acc_cnt, scan_cnt;
    logic [3:0]       acc_code, scan_code;
    logic [2:0]       col_hits, hit_sum;
    logic [1:0]       hit_row;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic [3:0] cand, cand_next;
    logic [3:0] code_next;
    logic       valid_next;
    logic       scan_none, scan_single, cnt_reached;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_i;
            row_sync <= row_meta;
        end
    end

    assign tc        = (div == DIV_LAST);
    assign scan_done = tc && (col_idx == 2'd3);
    assign col_o     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div      <= '0;
            col_idx  <= '0;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (tc) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
                acc_cnt  <= '0;
                acc_code <= '0;
            end else begin
                acc_cnt  <= scan_cnt;
                acc_code <= scan_code;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // Active-key count saturates at 2: only NONE/SINGLE/MULTI matter.
    always_comb begin
        col_hits = '0;
        hit_row  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                hit_row  = 2'(r);
            end
        end
        hit_sum   = {1'b0, acc_cnt} + col_hits;
        scan_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_code = acc_code;
        if (acc_cnt == 2'd0 && col_hits == 3'd1)
            scan_code = {hit_row, col_idx};
    end

    assign scan_none   = (scan_cnt == 2'd0);
    assign scan_single = (scan_cnt == 2'd1);
    assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign cnt_reached = (cnt_inc >= DEB_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code_o  <= '0;
            key_valid_o <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cand        <= cand_next;
            key_code_o  <= code_next;
            key_valid_o <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        code_next  = key_code_o;
        valid_next = 1'b0;
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (scan_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            code_next  = scan_code;
                            valid_next = 1'b1;
                            state_next = ST_PRESSED;
                        end else begin
                            cand_next  = scan_code;
                            cnt_next   = 4'd1;
                            state_next = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_single && scan_code == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_reached) begin
                            code_next  = cand;
                            valid_next = 1'b1;
                            state_next = ST_PRESSED;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = ST_IDLE;
                        end else begin
                            cnt_next   = 4'd1;
                            state_next = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_none) begin
                        cnt_next = cnt_inc;
                        if (cnt_reached)
                            state_next = ST_IDLE;
                    end else begin
                        state_next = ST_PRESSED;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        key_pressed_o = (state == ST_PRESSED) || (state == ST_RELEASE);
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with a keypad model; accepted key codes
// are queued as expectations and checked by an independent pulse monitor.
module tb_keypad_scanner_4x4;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    logic [15:0] keys;
    logic [3:0]  sb[$];
    int          total;
    int          bad;
    logic        prev_valid;

    keypad_scanner_4x4 #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .row_i(row),
        .col_o(col),
        .key_code_o(key_code),
        .key_valid_o(key_valid),
        .key_pressed_o(key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: row r pulled low when a pressed key (r,c) sits on a driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scans(input int k);
        repeat (16 * k) @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest expected code and last one cycle.
    initial begin
        logic [3:0] exp_code;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && key_valid) begin
                check("pulse_width", {31'd0, prev_valid}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {28'd0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    exp_code = sb.pop_front();
                    check("pulse_code", {28'd0, key_code}, {28'd0, exp_code});
                    check("pulse_pressed", {31'd0, key_pressed}, 32'd1);
                end
            end
            prev_valid = key_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        keys  = '0;
        rst_n = 1'b0;

        // 1. reset values and column sequence
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_pressed", {31'd0, key_pressed}, 32'd0);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            check("col_seq", {28'd0, col}, {28'd0, exp_col});
        end

        // 2. steady press of (2,1)
        sb.push_back(4'h9);
        keys[9] = 1'b1;
        scans(2);
        check("press_not_early", sb.size(), 32'd1);
        scans(1);
        check("press_drained", sb.size(), 32'd0);
        check("press_pressed", {31'd0, key_pressed}, 32'd1);
        check("press_code", {28'd0, key_code}, 32'h9);
        scans(10);
        check("hold_pressed", {31'd0, key_pressed}, 32'd1);

        // 5. release then re-press (3,3), then add (0,2)
        keys = '0;
        scans(2);
        check("rel_still_pressed", {31'd0, key_pressed}, 32'd1);
        scans(1);
        check("rel_pressed", {31'd0, key_pressed}, 32'd0);
        check("rel_code_kept", {28'd0, key_code}, 32'h9);
        sb.push_back(4'hF);
        keys[15] = 1'b1;
        scans(3);
        check("repress_drained", sb.size(), 32'd0);
        check("repress_code", {28'd0, key_code}, 32'hF);
        keys[2] = 1'b1;
        scans(5);
        check("second_key_code", {28'd0, key_code}, 32'hF);
        check("second_key_pressed", {31'd0, key_pressed}, 32'd1);
        keys = '0;
        scans(3);
        check("rel2_pressed", {31'd0, key_pressed}, 32'd0);

        // 6. reset during the second debounce scan of (2,1)
        keys[9] = 1'b1;
        scans(1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", {28'd0, col}, 32'hE);
        check("mid_rst_code", {28'd0, key_code}, 32'h0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        check("mid_rst_pressed", {31'd0, key_pressed}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(4'h9);
        scans(2);
        check("post_rst_not_early", sb.size(), 32'd1);
        check("post_rst_idle", {31'd0, key_pressed}, 32'd0);
        scans(1);
        check("post_rst_drained", sb.size(), 32'd0);
        check("post_rst_code", {28'd0, key_code}, 32'h9);
        keys = '0;
        scans(3);
        check("post_rst_release", {31'd0, key_pressed}, 32'd0);

        // 3. bounce on (1,3)
        keys[7] = 1'b1;
        scans(2);
        keys[7] = 1'b0;
        scans(1);
        keys[7] = 1'b1;
        scans(2);
        check("bounce_pressed_a", {31'd0, key_pressed}, 32'd0);
        keys[7] = 1'b0;
        scans(3);
        check("bounce_pressed_b", {31'd0, key_pressed}, 32'd0);
        check("bounce_code", {28'd0, key_code}, 32'h9);

        // 4. multi-key (0,0)+(3,3), then (0,0) alone
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        scans(8);
        check("multi_pressed", {31'd0, key_pressed}, 32'd0);
        keys[15] = 1'b0;
        sb.push_back(4'h0);
        scans(2);
        check("single_not_early", sb.size(), 32'd1);
        scans(1);
        check("single_drained", sb.size(), 32'd0);
        check("single_code", {28'd0, key_code}, 32'h0);
        check("single_pressed", {31'd0, key_pressed}, 32'd1);
        keys = '0;
        scans(3);
        check("final_release", {31'd0, key_pressed}, 32'd0);
        check("final_queue", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
